gpu_net_tx_arbiter: RTL and testbench

GPU_NET_TX_ARBITER -- requirements
Module: gpu_net_tx_arbiter

---
 rtl/gpu_net_tx_arbiter_pkg.sv | 16 +
 rtl/gpu_net_tx_arbiter_rr_core.sv | 32 +++
 rtl/gpu_net_tx_arbiter.sv | 98 +++++++++
 tb/tb_gpu_net_tx_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_net_tx_arbiter_pkg.sv
// Shared flit layout and output-register state encoding for the network TX arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package gpu_net_tx_arbiter_pkg;

    localparam int FLIT_W    = 16;
    localparam int DEST_MSB  = 15;
    localparam int DEST_LSB  = 10;
    localparam int PAYLOAD_W = 10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/gpu_net_tx_arbiter_rr_core.sv
// Combinational round-robin pick: search starts one past last_grant, first valid wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates the one-hot result with its own accept condition.
module rr_arbiter_core #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NREQ);
            if (!win_vld && req_valid[cand]) begin
                win_vld       = 1'b1;
                win_idx       = cand;
                win_oh[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_net_tx_arbiter.sv
// Round-robin merge of NREQ flit sources onto one network port; self-addressed flits are discarded (optional stats: GPU_NET_ARB_STATS_EN).
// Latency: accepted flit is presented on net_data_out one cycle after acceptance.
// Backpressure: single output register; accepts when empty or while the held flit leaves (no bubble).
module gpu_net_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int GPU_ID = 8,
    parameter int FLIT_W = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [NREQ*FLIT_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    output logic [FLIT_W-1:0]        net_data_out,
    output logic                     net_valid_out,
    input  logic                     net_ready_in,
    output logic [$clog2(NREQ)-1:0]  grant_idx,
    output logic                     drop_pulse
`ifdef GPU_NET_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]       grant_cnt
`endif
);

    import gpu_net_tx_arbiter_pkg::*;

    localparam int IDX_W  = $clog2(NREQ);
    localparam int DEST_W = DEST_MSB - DEST_LSB + 1;
    localparam logic [DEST_W-1:0] SELF_DEST = DEST_W'(GPU_ID);

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [NREQ-1:0]    win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [FLIT_W-1:0]  win_dat;
    logic               accept_ok;
    logic               accept;
    logic               is_drop;
    logic               xfer;

    rr_arbiter_core #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .win_oh     (win_oh),
        .win_idx    (win_idx),
        .win_vld    (win_vld)
    );

    // Reset gates acceptance so no requester sees a handshake while the block is held in reset.
    assign xfer      = net_valid_out && net_ready_in;
    assign accept_ok = ARESETn && ((state == EMPTY) || net_ready_in);
    assign req_ready = accept_ok ? win_oh : '0;
    assign accept    = accept_ok && win_vld;
    assign win_dat   = req_data[win_idx*FLIT_W +: FLIT_W];
    assign is_drop   = (win_dat[DEST_MSB:DEST_LSB] == SELF_DEST);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= EMPTY;
            net_valid_out <= 1'b0;
            net_data_out  <= '0;
            grant_idx     <= '0;
            drop_pulse    <= 1'b0;
            last_grant    <= IDX_W'(NREQ - 1);
        end else begin
            drop_pulse <= accept && is_drop;
            if (accept) begin
                last_grant <= win_idx;
            end
            // A dropped flit never occupies the output register, so it cannot cause FULL.
            if (accept && !is_drop) begin
                state         <= FULL;
                net_valid_out <= 1'b1;
                net_data_out  <= win_dat;
                grant_idx     <= win_idx;
            end else if (xfer) begin
                state         <= EMPTY;
                net_valid_out <= 1'b0;
            end
        end
    end

`ifdef GPU_NET_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                cnt <= '0;
            end else if (req_ready[i] && req_valid[i] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_gpu_net_tx_arbiter.sv
// Randomised and directed stimulus against a queue-based reference model; monitor pops expectations.
// Latency: n/a (bench).
// Backpressure: net_ready_in driven by the bench, stalls are both directed and random.
module tb_gpu_net_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int GPU_ID = 8;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [63:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] net_data_out;
    logic        net_valid_out;
    logic        net_ready_in;
    logic [1:0]  grant_idx;
    logic        drop_pulse;
`ifdef GPU_NET_ARB_STATS_EN
    logic [63:0] grant_cnt;
`endif

    always #5 ACLK = ~ACLK;

    gpu_net_tx_arbiter #(.NREQ(NREQ), .GPU_ID(GPU_ID), .FLIT_W(16)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .net_data_out  (net_data_out),
        .net_valid_out (net_valid_out),
        .net_ready_in  (net_ready_in),
        .grant_idx     (grant_idx),
        .drop_pulse    (drop_pulse)
`ifdef GPU_NET_ARB_STATS_EN
        ,
        .grant_cnt     (grant_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    bit          in_rst = 1'b1;
    logic [17:0] exp_q[$];      // {requester, flit} expected on the output, in order
    bit          drop_q[$];     // expected drop_pulse, one entry per cycle
    bit          m_full;
    int          lg;
    int unsigned m_cnt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd_data(input bit allow_drop);
        logic [63:0] d;
        logic [15:0] f;
        for (int i = 0; i < 4; i++) begin
            f = 16'($urandom);
            if (allow_drop && $urandom_range(0, 3) == 0) f[15:10] = 6'(GPU_ID);
            else if (f[15:10] == 6'(GPU_ID)) f[15:10] = 6'(GPU_ID + 1);
            d[i*16 +: 16] = f;
        end
        return d;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        drop_q.delete();
        m_full = 1'b0;
        lg     = NREQ - 1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Evaluated just before the rising edge with inputs settled.
    task automatic model_step();
        bit          allow;
        bit          found;
        bit          drop;
        int          w;
        logic [3:0]  exp_rdy;
        logic [15:0] flit;
        allow = !m_full || net_ready_in;
        found = 1'b0;
        w     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (lg + k) % NREQ;
            if (!found && req_valid[c]) begin
                found = 1'b1;
                w     = c;
            end
        end
        exp_rdy = (allow && found) ? 4'(1 << w) : 4'b0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        flit = req_data[w*16 +: 16];
        drop = allow && found && (flit[15:10] == 6'(GPU_ID));
        if (allow && found) begin
            lg = w;
            if (m_cnt[w] < 32'hFFFF) m_cnt[w]++;
        end
        if (allow && found && !drop) begin
            exp_q.push_back({2'(w), flit});
            m_full = 1'b1;
        end else if (m_full && net_ready_in) begin
            m_full = 1'b0;
        end
        drop_q.push_back(drop);
    endtask

    task automatic step(input logic [3:0] v, input logic nr, input logic [63:0] d);
        @(negedge ACLK);
        req_valid    = v;
        net_ready_in = nr;
        req_data     = d;
        #4;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        in_rst  = 1'b1;
        #1;
        check("rst_net_valid", 32'(net_valid_out), 32'd0);
        check("rst_net_data", 32'(net_data_out), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_drop", 32'(drop_pulse), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        model_clear();
        repeat (2) @(negedge ACLK);
        ARESETn   = 1'b1;
        in_rst    = 1'b0;
        req_valid = 4'b0;
        #4;
        model_step();
    endtask

    // Monitor: compares registered outputs mid-cycle against the scoreboard.
    initial begin
        forever begin
            @(negedge ACLK);
            #3;
            if (!in_rst) begin
                check("drop_pulse", 32'(drop_pulse), 32'(drop_q.size() > 0 ? drop_q.pop_front() : 1'b0));
                if (net_valid_out) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 32'(net_valid_out), 32'd0);
                    end else begin
                        check("net_data_out", 32'(net_data_out), 32'(exp_q[0][15:0]));
                        check("grant_idx", 32'(grant_idx), 32'(exp_q[0][17:16]));
                        if (net_ready_in) void'(exp_q.pop_front());
                    end
                end else if (exp_q.size() != 0) begin
                    check("missing_valid", 32'(net_valid_out), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        ARESETn      = 1'b0;
        req_valid    = 4'hF;
        net_ready_in = 1'b0;
        req_data     = rnd_data(1'b0);
        model_clear();
        do_reset();

        // Requesters 0 and 2 streaming, output always ready.
        repeat (20) step(4'b0101, 1'b1, rnd_data(1'b0));
        repeat (2) step(4'b0000, 1'b1, rnd_data(1'b0));

        // All valid, 5-cycle stall after first accept, then release.
        do_reset();
        step(4'hF, 1'b1, rnd_data(1'b0));
        repeat (5) step(4'hF, 1'b0, rnd_data(1'b0));
        repeat (8) step(4'hF, 1'b1, rnd_data(1'b0));
        repeat (3) step(4'b0000, 1'b1, rnd_data(1'b0));

        // Self-addressed flit from requester 1.
        d = rnd_data(1'b0);
        d[31:16] = 16'h2123;
        step(4'b0010, 1'b1, d);
        repeat (2) step(4'b0000, 1'b1, rnd_data(1'b0));

        // Requester 3 to node 9 from EMPTY.
        d = rnd_data(1'b0);
        d[63:48] = 16'h2523;
        step(4'b1000, 1'b1, d);
        repeat (2) step(4'b0000, 1'b1, rnd_data(1'b0));

        // Reset while FULL and stalled, then requester 0 must win first.
        repeat (3) step(4'hF, 1'b0, rnd_data(1'b0));
        do_reset();
        repeat (6) step(4'hF, 1'b1, rnd_data(1'b0));

        // Random traffic with drops and backpressure.
        repeat (600) step(4'($urandom), ($urandom_range(0, 3) != 0), rnd_data(1'b1));
        repeat (3) step(4'b0000, 1'b1, rnd_data(1'b0));

`ifdef GPU_NET_ARB_STATS_EN
        for (int i = 0; i < 4; i++) check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), m_cnt[i]);
        repeat (70000) step(4'b0001, 1'b1, rnd_data(1'b1));
        repeat (2) step(4'b0000, 1'b1, rnd_data(1'b0));
        check("grant_cnt_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
